axis_iq16_fir_scheduler: RTL and testbench

//  Sequences 16-bit {I[15:8],Q[7:0]} AXIS pairs into the shared 2-channel, 8-bit interleaved FIR input as I then Q.

---
 rtl/axis_iq16_fir_scheduler_pkg.sv | 26 ++
 rtl/axis_iq16_fir_scheduler_if.sv | 29 ++
 rtl/axis_iq16_fir_scheduler_credit_counter.sv | 42 ++++
 rtl/axis_iq16_fir_scheduler.sv | 133 +++++++++++++
 tb/tb_axis_iq16_fir_scheduler.sv | 394 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_iq16_fir_scheduler_pkg.sv
// Shared IQ widths, channel tags and FSM encodings for the
// IQ pair to interleaved-FIR scheduler.
package axis_iq16_fir_scheduler_pkg;

    localparam int IQ_W   = 8;
    localparam int PAIR_W = 16;

    localparam logic CH_I = 1'b0;
    localparam logic CH_Q = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND_I = 2'd1,
        ST_SEND_Q = 2'd2
    } state_t;

    // Upper byte of a pair is I, lower byte is Q.
    function automatic logic [IQ_W-1:0] pair_i(input logic [PAIR_W-1:0] p);
        return p[PAIR_W-1:IQ_W];
    endfunction

    function automatic logic [IQ_W-1:0] pair_q(input logic [PAIR_W-1:0] p);
        return p[IQ_W-1:0];
    endfunction

endpackage

// File: rtl/axis_iq16_fir_scheduler_if.sv
// AXI-Stream bundle used on both sides of the scheduler;
// DATA_W is 16 on the pair side and 8 on the FIR side.
interface axis_iq16_fir_scheduler_if #(
    parameter int DATA_W = 8
);

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );

endinterface

// File: rtl/axis_iq16_fir_scheduler_credit_counter.sv
// Credit counter for pairs in flight through FIR and packer:
// counts up on accept, down on retire, flags retire-at-zero.
module axis_credit_counter #(
    parameter int MAX_INFLIGHT = 16,
    parameter int CNT_W        = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_INFLIGHT);

    // Full is decoded from the registered count only, so a retire
    // never reaches the upstream ready in the same cycle.
    assign full = (count >= LIMIT);

    // Count update; simultaneous inc and dec cancel out.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            case ({inc, dec})
                2'b10: count <= count + CNT_W'(1);
                2'b01: begin
                    if (count == '0) begin
                        underflow <= 1'b1;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axis_iq16_fir_scheduler.sv
// Splits {I,Q} pairs into I-then-Q 8-bit beats for the shared FIR,
// tags the channel, regenerates TLAST and limits pairs in flight.
module axis_iq16_fir_scheduler #(
    parameter int MAX_INFLIGHT = 16,
    parameter int FRAME_LEN    = 0,
    parameter int CNT_W        = 8
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    axis_iq16_fir_scheduler_if.slave  s_axis,
    axis_iq16_fir_scheduler_if.master m_axis,
    input  logic                      pair_done,
    output logic [CNT_W-1:0]          inflight,
    output logic                      err_underflow
);

    import axis_iq16_fir_scheduler_pkg::*;

    localparam logic [CNT_W-1:0] LAST_IDX =
        (FRAME_LEN > 0) ? CNT_W'(FRAME_LEN - 1) : '0;

    state_t            state;
    logic [IQ_W-1:0]   hold_q;
    logic              hold_last;
    logic [CNT_W-1:0]  frame_cnt;

    logic [IQ_W-1:0]   m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_user;

    logic              full;
    logic              s_rdy;
    logic              s_hs;
    logic              m_hs;
    logic              frame_end;
    logic              unused_tuser;

    assign unused_tuser = s_axis.tuser;

    assign m_axis.tdata  = m_data;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tlast  = m_last;
    assign m_axis.tuser  = m_user;

    // Take a new pair when idle, or while the Q beat leaves (back-to-back).
    assign s_rdy = aresetn && !full &&
                   ((state == ST_IDLE) ||
                    ((state == ST_SEND_Q) && m_axis.tready));

    assign s_axis.tready = s_rdy;
    assign s_hs = s_axis.tvalid && s_rdy;
    assign m_hs = m_valid && m_axis.tready;

    // With a fixed frame length the end is counted, otherwise it
    // follows the TLAST captured with the pair.
    assign frame_end = (FRAME_LEN == 0) ? hold_last
                                        : (frame_cnt == LAST_IDX);

    // Sequencer: registered beat outputs, pair hold and frame count.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            m_user    <= 1'b0;
            hold_q    <= '0;
            hold_last <= 1'b0;
            frame_cnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (s_hs) begin
                        state     <= ST_SEND_I;
                        m_data    <= pair_i(s_axis.tdata);
                        m_valid   <= 1'b1;
                        m_user    <= CH_I;
                        m_last    <= 1'b0;
                        hold_q    <= pair_q(s_axis.tdata);
                        hold_last <= s_axis.tlast;
                    end
                end
                ST_SEND_I: begin
                    if (m_hs) begin
                        state  <= ST_SEND_Q;
                        m_data <= hold_q;
                        m_user <= CH_Q;
                        m_last <= frame_end;
                    end
                end
                ST_SEND_Q: begin
                    if (m_hs) begin
                        frame_cnt <= m_last ? '0
                                            : frame_cnt + CNT_W'(1);
                        if (s_hs) begin
                            state     <= ST_SEND_I;
                            m_data    <= pair_i(s_axis.tdata);
                            m_user    <= CH_I;
                            m_last    <= 1'b0;
                            hold_q    <= pair_q(s_axis.tdata);
                            hold_last <= s_axis.tlast;
                        end else begin
                            state   <= ST_IDLE;
                            m_data  <= '0;
                            m_valid <= 1'b0;
                            m_user  <= 1'b0;
                            m_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

    axis_credit_counter #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CNT_W        (CNT_W)
    ) u_credit (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .inc       (s_hs),
        .dec       (pair_done),
        .count     (inflight),
        .full      (full),
        .underflow (err_underflow)
    );

endmodule

// File: tb/tb_axis_iq16_fir_scheduler.sv
// Bench for axis_iq16_fir_scheduler: vector table, scoreboard
// queues, and hand sequences for stalls, credits and reset.
module tb_axis_iq16_fir_scheduler;

    typedef struct {
        logic [7:0] d;
        logic       u;
        logic       l;
    } beat_t;

    typedef struct {
        logic [15:0] pair;
        logic        last;
        logic [7:0]  exp_i;
        logic [7:0]  exp_q;
        logic        exp_last;
    } vec_t;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    int   cyc     = 0;

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc++;

    axis_iq16_fir_scheduler_if #(.DATA_W(16)) a_s ();
    axis_iq16_fir_scheduler_if #(.DATA_W(8))  a_m ();
    axis_iq16_fir_scheduler_if #(.DATA_W(16)) b_s ();
    axis_iq16_fir_scheduler_if #(.DATA_W(8))  b_m ();

    logic       a_done;
    logic [7:0] a_inflight;
    logic       a_err;
    logic       b_done;
    logic [7:0] b_inflight;
    logic       b_err;

    axis_iq16_fir_scheduler #(
        .MAX_INFLIGHT (2),
        .FRAME_LEN    (0),
        .CNT_W        (8)
    ) dut_a (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis        (a_s),
        .m_axis        (a_m),
        .pair_done     (a_done),
        .inflight      (a_inflight),
        .err_underflow (a_err)
    );

    axis_iq16_fir_scheduler #(
        .MAX_INFLIGHT (16),
        .FRAME_LEN    (2),
        .CNT_W        (8)
    ) dut_b (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis        (b_s),
        .m_axis        (b_m),
        .pair_done     (b_done),
        .inflight      (b_inflight),
        .err_underflow (b_err)
    );

    int n_pass = 0;
    int n_tot  = 0;

    beat_t qa[$];
    beat_t qb[$];

    int   a_beats = 0;
    int   b_beats = 0;
    bit   a_stalled = 0;
    logic [9:0] a_saved;
    logic a_pre_valid;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic beat_t mk(input logic [7:0] d, input logic u,
                                 input logic l);
        beat_t b;
        b.d = d;
        b.u = u;
        b.l = l;
        return b;
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Scoreboard for DUT A plus hold-while-stalled check.
    always @(negedge aclk) begin
        beat_t e;
        if (aresetn && a_m.tvalid && a_m.tready) begin
            a_beats++;
            if (qa.size() == 0) begin
                n_tot++;
                $display("FAIL a_extra_beat: got %0h expected none",
                         a_m.tdata);
            end else begin
                e = qa.pop_front();
                chk("a_beat", {a_m.tdata, a_m.tuser, a_m.tlast},
                    {e.d, e.u, e.l});
            end
        end
        if (aresetn && a_stalled)
            chk("a_hold", {a_m.tdata, a_m.tuser, a_m.tlast, a_m.tvalid},
                {a_saved, 1'b1});
        a_stalled = aresetn && a_m.tvalid && !a_m.tready;
        a_saved   = {a_m.tdata, a_m.tuser, a_m.tlast};
    end

    // Scoreboard for DUT B.
    always @(negedge aclk) begin
        beat_t e;
        if (aresetn && b_m.tvalid && b_m.tready) begin
            b_beats++;
            if (qb.size() == 0) begin
                n_tot++;
                $display("FAIL b_extra_beat: got %0h expected none",
                         b_m.tdata);
            end else begin
                e = qb.pop_front();
                chk("b_beat", {b_m.tdata, b_m.tuser, b_m.tlast},
                    {e.d, e.u, e.l});
            end
        end
    end

    // Present a pair on A, push its two beats when accepted.
    task automatic send_a(input logic [15:0] p, input logic last,
                          input beat_t ei, input beat_t eq,
                          input string name);
        bit ok = 0;
        a_s.tdata  = p;
        a_s.tlast  = last;
        a_s.tvalid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge aclk);
            ok = a_s.tready;
        end
        chk({name, "_acc"}, {31'd0, ok}, 32'd1);
        a_pre_valid = a_m.tvalid;
        if (ok) begin
            qa.push_back(ei);
            qa.push_back(eq);
        end
        step();
        a_s.tvalid = 1'b0;
    endtask

    task automatic wait_drain_a(input string name);
        for (int k = 0; k < 60 && qa.size() != 0; k++) @(negedge aclk);
        chk(name, qa.size(), 0);
    endtask

    task automatic retire_a(input int n);
        for (int k = 0; k < n; k++) begin
            a_done = 1'b1;
            step();
            a_done = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pairs[4];
        int          acc[4];
        bit          ok;
        int          b0;

        vecs[0] = '{16'h1234, 1'b0, 8'h12, 8'h34, 1'b0};
        vecs[1] = '{16'hFF00, 1'b1, 8'hFF, 8'h00, 1'b1};
        vecs[2] = '{16'h00FF, 1'b0, 8'h00, 8'hFF, 1'b0};
        vecs[3] = '{16'h8001, 1'b1, 8'h80, 8'h01, 1'b1};

        pairs[0] = 16'h0102;
        pairs[1] = 16'h0304;
        pairs[2] = 16'h0506;
        pairs[3] = 16'h0708;

        a_s.tdata = '0; a_s.tvalid = 0; a_s.tlast = 0; a_s.tuser = 0;
        b_s.tdata = '0; b_s.tvalid = 0; b_s.tlast = 0; b_s.tuser = 0;
        a_m.tready = 0; b_m.tready = 0;
        a_done = 0; b_done = 0;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_a_valid", a_m.tvalid, 0);
        chk("rst_a_data", {a_m.tdata, a_m.tuser, a_m.tlast}, 0);
        chk("rst_a_inflight", a_inflight, 0);
        chk("rst_a_err", a_err, 0);
        chk("rst_a_sready", a_s.tready, 0);
        chk("rst_b_valid", b_m.tvalid, 0);
        step();
        aresetn = 1'b1;
        @(negedge aclk);
        chk("a_sready_idle", a_s.tready, 1);

        // Single pair, latency and tagging
        step();
        a_m.tready = 1'b1;
        send_a(16'hA55A, 1'b1, mk(8'hA5, 0, 0), mk(8'h5A, 1, 1), "t1");
        chk("t1_pre_valid", a_pre_valid, 0);
        chk("t1_lat_valid", a_m.tvalid, 1);
        chk("t1_lat_data", a_m.tdata, 8'hA5);
        wait_drain_a("t1_drain");
        step();
        retire_a(1);
        @(negedge aclk);
        chk("t1_inflight", a_inflight, 0);

        // Vector table
        for (int i = 0; i < 4; i++) begin
            step();
            send_a(vecs[i].pair, vecs[i].last,
                   mk(vecs[i].exp_i, 0, 0),
                   mk(vecs[i].exp_q, 1, vecs[i].exp_last), "vec");
            wait_drain_a("vec_drain");
            step();
            retire_a(1);
        end
        @(negedge aclk);
        chk("vec_inflight", a_inflight, 0);

        // Fixed frame length streaming on B
        step();
        b_m.tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_s.tdata  = pairs[i];
            b_s.tvalid = 1'b1;
            ok = 0;
            for (int k = 0; k < 20 && !ok; k++) begin
                @(negedge aclk);
                ok = b_s.tready;
            end
            chk("t2_acc", {31'd0, ok}, 1);
            acc[i] = cyc;
            if (ok) begin
                qb.push_back(mk(pairs[i][15:8], 0, 0));
                qb.push_back(mk(pairs[i][7:0], 1, (i % 2) == 1));
            end
            step();
        end
        b_s.tvalid = 1'b0;
        for (int i = 0; i < 3; i++)
            chk("t2_rate", acc[i+1] - acc[i], 2);
        for (int k = 0; k < 40 && qb.size() != 0; k++) @(negedge aclk);
        step();
        @(negedge aclk);
        chk("t2_drain", qb.size(), 0);
        chk("t2_beats", b_beats, 8);
        chk("t2_inflight", b_inflight, 4);
        chk("t2_err", b_err, 0);

        // Toggling downstream ready
        b0 = a_beats;
        step();
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    a_m.tready = (k % 2) == 0;
                    step();
                end
            end
            begin
                send_a(16'h3C5A, 1'b0, mk(8'h3C, 0, 0),
                       mk(8'h5A, 1, 0), "t3a");
                send_a(16'hC3A5, 1'b1, mk(8'hC3, 0, 0),
                       mk(8'hA5, 1, 1), "t3b");
            end
        join
        a_m.tready = 1'b1;
        wait_drain_a("t3_drain");
        step();
        @(negedge aclk);
        chk("t3_count", a_beats - b0, 4);
        step();
        retire_a(2);

        // Credit limit stalls the third pair
        send_a(16'h1122, 1'b0, mk(8'h11, 0, 0), mk(8'h22, 1, 0), "t4a");
        send_a(16'h3344, 1'b0, mk(8'h33, 0, 0), mk(8'h44, 1, 0), "t4b");
        a_s.tdata  = 16'h5566;
        a_s.tlast  = 1'b0;
        a_s.tvalid = 1'b1;
        repeat (4) @(negedge aclk);
        chk("t4_stall", a_s.tready, 0);
        chk("t4_full", a_inflight, 2);
        step();
        a_done = 1'b1;
        @(negedge aclk);
        chk("t4_no_comb", a_s.tready, 0);
        step();
        a_done = 1'b0;
        @(negedge aclk);
        chk("t4_resume", a_s.tready, 1);
        if (a_s.tready) begin
            qa.push_back(mk(8'h55, 0, 0));
            qa.push_back(mk(8'h66, 1, 0));
        end
        step();
        a_s.tvalid = 1'b0;
        wait_drain_a("t4_drain");
        @(negedge aclk);
        chk("t4_inflight2", a_inflight, 2);
        step();
        retire_a(1);
        @(negedge aclk);
        chk("t4_inflight1", a_inflight, 1);

        // Accept and retire in the same cycle, then underflow
        step();
        a_s.tdata  = 16'h7788;
        a_s.tlast  = 1'b0;
        a_s.tvalid = 1'b1;
        a_done     = 1'b1;
        @(negedge aclk);
        chk("t5_rdy", a_s.tready, 1);
        if (a_s.tready) begin
            qa.push_back(mk(8'h77, 0, 0));
            qa.push_back(mk(8'h88, 1, 0));
        end
        step();
        a_s.tvalid = 1'b0;
        a_done     = 1'b0;
        @(negedge aclk);
        chk("t5_inflight", a_inflight, 1);
        chk("t5_err0", a_err, 0);
        wait_drain_a("t5_drain");
        step();
        retire_a(1);
        @(negedge aclk);
        chk("t5_zero", a_inflight, 0);
        step();
        retire_a(1);
        @(negedge aclk);
        chk("t5_err1", a_err, 1);
        chk("t5_stay0", a_inflight, 0);

        // Reset between I and Q beats
        step();
        a_m.tready = 1'b0;
        send_a(16'hBEEF, 1'b0, mk(8'hBE, 0, 0), mk(8'hEF, 1, 0), "t6a");
        a_m.tready = 1'b1;
        step();
        a_m.tready = 1'b0;
        @(negedge aclk);
        chk("t6_in_q", {a_m.tvalid, a_m.tuser}, 2'b11);
        step();
        aresetn = 1'b0;
        qa.delete();
        step();
        step();
        @(negedge aclk);
        chk("t6_rst_valid", a_m.tvalid, 0);
        chk("t6_rst_data", {a_m.tdata, a_m.tuser, a_m.tlast}, 0);
        chk("t6_rst_inflight", a_inflight, 0);
        chk("t6_rst_err", a_err, 0);
        step();
        aresetn    = 1'b1;
        a_m.tready = 1'b1;
        repeat (2) @(negedge aclk);
        chk("t6_no_q", a_m.tvalid, 0);
        step();
        send_a(16'h1234, 1'b0, mk(8'h12, 0, 0), mk(8'h34, 1, 0), "t6b");
        wait_drain_a("t6_drain");
        step();
        retire_a(1);
        @(negedge aclk);
        chk("t6_inflight", a_inflight, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
